lcd_receptor: RTL and testbench
===============================

Name: lcd_receptor

Overview:
- Display-side responder for the parallel HD44780-style LCD bus (LCD_data/LCD_en/LCD_rw/LCD_rs) that our FPGA test writers drive.
- Decodes command and data transactions into a 2x16 character buffer, tracks the cursor and emulates the busy flag.
- Lets benches and on-chip checkers verify LCD writer output without a physical panel.

Parameters:
CMD_CYCLES, 4, busy duration in clk cycles after a data write or non-clear command (>=1)
CLEAR_CYCLES, 40, busy duration after clear display (>=32)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
LCD_en  in  1  bus enable; a transaction is taken on its falling edge
LCD_rw  in  1  0 = write, 1 = read
LCD_rs  in  1  0 = command/status, 1 = data
LCD_data_in  in  8  bus data from writer
LCD_data_out  out  8  read data driven back to the bus
LCD_data_oe  out  1  LCD_data_out valid/driven
rd_addr  in  5  buffer read port: {line, col[3:0]}
rd_char  out  8  buffer[rd_addr], registered, 1-cycle latency
busy  out  1  busy flag
cursor  out  7  current DDRAM address (0x00-0x0F line 0, 0x40-0x4F line 1)
wr_count  out  8  number of accepted data writes, saturating at 255
overrun  out  1  sticky: transaction arrived while busy
addr_err  out  1  sticky: set-address command outside the 2x16 window

Behaviour:
Reset, asynchronous on rst_n low:
- All 32 buffer entries = 0x20.
- cursor = 0x00, busy = 0, wr_count = 0, overrun = 0, addr_err = 0.
- LCD_data_out = 0x00, LCD_data_oe = 0, rd_char = 0x20, en_q = 0, FSM = IDLE.
- Reset asserted mid-clear or mid-busy aborts immediately to the reset state.

Strobe:
- en_q registers LCD_en.
- strobe = en_q & ~LCD_en.
- rs, rw and data are sampled in the strobe cycle.

FSM IDLE / BUSY / CLEAR:
- IDLE, strobe with rw=0, rs=1:
  - buffer[cursor] <= data; cursor advances; wr_count increments.
  - busy = 1 starting the next cycle; go to BUSY for CMD_CYCLES.
- IDLE, strobe with rw=0, rs=0, data[7]=1 (set DDRAM address):
  - If data[5:4]==0: cursor <= {data[6], 2'b00, data[3:0]}.
  - Otherwise: cursor unchanged and addr_err set.
  - Go to BUSY.
- IDLE, rw=0, rs=0, data==0x01 (clear display):
  - Go to CLEAR.
  - Write 0x20 to entry k during the k-th cycle, k = 0..31.
  - Busy held for CLEAR_CYCLES in total; cursor = 0x00 at exit.
- IDLE, rw=0, rs=0, data==0x02 or 0x03 (return home): cursor = 0x00; go to BUSY.
- IDLE, any other command: no state effect; go to BUSY.
- BUSY / CLEAR:
  - Down-counter; return to IDLE (busy = 0) when it reaches 0.
  - Busy lasts exactly CMD_CYCLES (resp. CLEAR_CYCLES) cycles.
- Any write strobe or data-read strobe while busy: ignored; overrun set.

Cursor advance:
- col 0..14 -> col+1.
- 0x0F -> 0x40.
- 0x4F -> 0x00 (wrap).

Status read (rw=1, rs=0):
- While LCD_en=1: LCD_data_oe = 1 and LCD_data_out = {busy, cursor}, registered one cycle after the condition.
- Allowed at any time; never sets overrun.

Data read (rw=1, rs=1):
- While LCD_en=1 and not busy: LCD_data_oe = 1 and LCD_data_out = buffer[cursor].
- On strobe: cursor advances, then BUSY for CMD_CYCLES.

General:
- LCD_data_oe drops the cycle after LCD_en falls.
- rd_char is independent of the FSM; during CLEAR it returns old or new content per entry with no glitching beyond that.
- Simultaneous strobe and counter expiry: the strobe is seen as busy, so overrun is set.

Test Plan:
- Reset, then drive 0x84 cmd, data "TP OC1", 0xC0 cmd, data "Caminho de Dados", each strobe spaced CMD_CYCLES+2 -> buffer[4..9] = "TP OC1", buffer[16..31] = "Caminho de Dados", cursor = 0x00 after wrap, wr_count = 22, overrun = 0.
- Write 'A' then strobe 'B' 1 cycle later -> buffer holds 'A' only, overrun = 1, wr_count = 1.
- Fill buffer, send 0x01, poll status reads -> LCD_data_out[7] = 1 for exactly 40 cycles, then 0x00; all rd_char = 0x20.
- Cursor at 0x0F, write 'X', 'Y' -> buffer[15] = 'X', buffer[16] = 'Y', cursor = 0x41.
- Cmd 0xA0 (col 0x20) -> addr_err = 1, cursor unchanged; cmd 0x38 -> busy 4 cycles, no buffer change.
- Assert rst_n low at cycle 10 of CLEAR -> busy = 0, cursor = 0x00, all entries 0x20 immediately, no pending writes.

Source files
------------

// File: rtl/lcd_receptor.sv
// lcd_receptor: display-side responder for an HD44780-style parallel LCD bus.
// A transaction is taken on the falling edge of LCD_en. Data writes go into a
// 2x16 character buffer at the cursor, commands move the cursor or clear the
// buffer, and a busy flag is emulated for a fixed number of clk cycles after
// every accepted transaction.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   LCD_en           bus enable, transaction strobed on its falling edge
//   LCD_rw           0 = write, 1 = read
//   LCD_rs           0 = command/status, 1 = data
//   LCD_data_in      bus data from the writer
//   LCD_data_out     read data back to the bus (valid when LCD_data_oe)
//   LCD_data_oe      LCD_data_out driven
//   rd_addr          side read port address {line, col[3:0]}
//   rd_char          buffer[rd_addr], registered, one cycle latency
//   busy             emulated busy flag
//   cursor           DDRAM address (0x00-0x0F line 0, 0x40-0x4F line 1)
//   wr_count         accepted data writes, saturating at 255
//   overrun          sticky: write or data-read strobe arrived while busy
//   addr_err         sticky: set-address command outside the 2x16 window
//   dbg_state_o      current FSM state (0 idle, 1 busy, 2 clear)
//
// Bus handshake: the writer owns LCD_rw/LCD_rs/LCD_data_in while LCD_en is
// high; the transaction is consumed in the single cycle where the registered
// enable is 1 and the live enable is 0. There is no back-pressure; a
// transaction that lands while busy is dropped and flagged in overrun.
module lcd_receptor #(
  parameter int CMD_CYCLES   = 4,
  parameter int CLEAR_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LCD_en,
  input  logic       LCD_rw,
  input  logic       LCD_rs,
  input  logic [7:0] LCD_data_in,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic [6:0] cursor,
  output logic [7:0] wr_count,
  output logic       overrun,
  output logic       addr_err,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_CLEAR = 2'd2} state_e;

  // Counters are loaded with N-1 so that busy lasts exactly N cycles.
  localparam logic [15:0] CMD_LOAD = 16'(CMD_CYCLES - 1);
  localparam logic [15:0] CLR_LOAD = 16'(CLEAR_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  clr_k_q, clr_k_d;
  logic [6:0]  cursor_q, cursor_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic        overrun_q, overrun_d;
  logic        addr_err_q, addr_err_d;
  logic        en_q;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic [7:0]  rd_char_q;
  logic [7:0]  buf_q [32];

  logic        strobe;
  logic        busy_w;
  logic [4:0]  cur_idx;
  logic        buf_we;
  logic [4:0]  buf_waddr;
  logic [7:0]  buf_wdata;

  assign strobe  = en_q & ~LCD_en;
  assign busy_w  = (state_q != S_IDLE);
  assign cur_idx = {cursor_q[6], cursor_q[3:0]};

  // Column 15 of line 0 continues on line 1; column 15 of line 1 wraps home.
  function automatic logic [6:0] next_cursor(input logic [6:0] c);
    if (c[3:0] == 4'hF) return c[6] ? 7'h00 : 7'h40;
    else                return c + 7'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_k_d    = clr_k_q;
    cursor_d   = cursor_q;
    wr_count_d = wr_count_q;
    overrun_d  = overrun_q;
    addr_err_d = addr_err_q;
    buf_we     = 1'b0;
    buf_waddr  = cur_idx;
    buf_wdata  = LCD_data_in;
    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          state_d = S_BUSY;
          cnt_d   = CMD_LOAD;
          if (!LCD_rw) begin
            if (LCD_rs) begin
              buf_we   = 1'b1;
              cursor_d = next_cursor(cursor_q);
              if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
            end else if (LCD_data_in[7]) begin
              if (LCD_data_in[5:4] == 2'b00)
                cursor_d = {LCD_data_in[6], 2'b00, LCD_data_in[3:0]};
              else
                addr_err_d = 1'b1;
            end else if (LCD_data_in == 8'h01) begin
              state_d  = S_CLEAR;
              cnt_d    = CLR_LOAD;
              clr_k_d  = 6'd0;
              cursor_d = 7'h00;
            end else if (LCD_data_in[7:1] == 7'h01) begin
              cursor_d = 7'h00;
            end
          end else if (LCD_rs) begin
            cursor_d = next_cursor(cursor_q);
          end else begin
            // Status read strobe: no effect, stay idle.
            state_d = S_IDLE;
            cnt_d   = cnt_q;
          end
        end
      end
      S_BUSY, S_CLEAR: begin
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
        if (strobe && (!LCD_rw || LCD_rs)) overrun_d = 1'b1;
        // Clear sweeps one entry per cycle from the first CLEAR cycle on.
        if (state_q == S_CLEAR && !clr_k_q[5]) begin
          buf_we    = 1'b1;
          buf_waddr = clr_k_q[4:0];
          buf_wdata = 8'h20;
          clr_k_d   = clr_k_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-back path: status is allowed any time, data only when not busy.
  always_comb begin
    dout_d = 8'h00;
    oe_d   = 1'b0;
    if (LCD_en && LCD_rw) begin
      if (!LCD_rs) begin
        oe_d   = 1'b1;
        dout_d = {busy_w, cursor_q};
      end else if (!busy_w) begin
        oe_d   = 1'b1;
        dout_d = buf_q[cur_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      clr_k_q    <= 6'd0;
      cursor_q   <= 7'h00;
      wr_count_q <= 8'h00;
      overrun_q  <= 1'b0;
      addr_err_q <= 1'b0;
      en_q       <= 1'b0;
      dout_q     <= 8'h00;
      oe_q       <= 1'b0;
      rd_char_q  <= 8'h20;
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_k_q    <= clr_k_d;
      cursor_q   <= cursor_d;
      wr_count_q <= wr_count_d;
      overrun_q  <= overrun_d;
      addr_err_q <= addr_err_d;
      en_q       <= LCD_en;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      rd_char_q  <= buf_q[rd_addr];
      if (buf_we) buf_q[buf_waddr] <= buf_wdata;
    end
  end

  assign LCD_data_out = dout_q;
  assign LCD_data_oe  = oe_q;
  assign rd_char      = rd_char_q;
  assign busy         = busy_w;
  assign cursor       = cursor_q;
  assign wr_count     = wr_count_q;
  assign overrun      = overrun_q;
  assign addr_err     = addr_err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lcd_receptor.sv
// Testbench for lcd_receptor: table-driven write sequence plus hand-written
// corner sequences; buffer contents checked through a scoreboard queue.
module tb_lcd_receptor;

  localparam int CMD_CYCLES   = 4;
  localparam int CLEAR_CYCLES = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       LCD_en = 1'b0;
  logic       LCD_rw = 1'b0;
  logic       LCD_rs = 1'b0;
  logic [7:0] LCD_data_in = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;
  logic [7:0] rd_char;
  logic       busy;
  logic [6:0] cursor;
  logic [7:0] wr_count;
  logic       overrun;
  logic       addr_err;
  logic [1:0] dbg_state_o;

  always #5 clk = ~clk;

  lcd_receptor #(.CMD_CYCLES(CMD_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .LCD_en(LCD_en), .LCD_rw(LCD_rw), .LCD_rs(LCD_rs),
    .LCD_data_in(LCD_data_in), .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
    .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy), .cursor(cursor),
    .wr_count(wr_count), .overrun(overrun), .addr_err(addr_err),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
  endtask

  // Expected char is queued when the address is driven, compared when rd_char returns.
  task automatic check_buf(input int idx);
    logic [7:0] e;
    exp_q.push_back(model[idx]);
    @(negedge clk);
    rd_addr = 5'(idx);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("buf[%0d]", idx), {24'd0, rd_char}, {24'd0, e});
  endtask

  task automatic check_all_buf();
    for (int i = 0; i < 32; i++) check_buf(i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; LCD_en = 1'b0; LCD_rw = 1'b0; LCD_rs = 1'b0; LCD_data_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
  endtask

  // Returns at the falling clk edge just after the strobe edge.
  task automatic bus_strobe(input logic rw, input logic rs, input logic [7:0] d);
    @(negedge clk);
    LCD_rw = rw; LCD_rs = rs; LCD_data_in = d; LCD_en = 1'b1;
    @(negedge clk);
    LCD_en = 1'b0;
    @(negedge clk);
    LCD_rw = 1'b0;
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    bus_strobe(1'b0, rs, d);
    repeat (CMD_CYCLES + 2) @(negedge clk);
  endtask

  // Counts busy cycles starting at the current falling edge.
  task automatic count_busy(input int window, output int n);
    n = 0;
    for (int i = 0; i < window; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [6:0] exp_cursor;
    logic [7:0] exp_wr;
  } vec_t;

  vec_t  vecs[24];
  string s1 = "TP OC1";
  string s2 = "Caminho de Dados";
  int    n;

  initial begin
    // ---------------- reset state ----------------
    model_clear();
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst cursor", {25'd0, cursor}, 32'h00);
    check("rst wr_count", {24'd0, wr_count}, 32'd0);
    check("rst overrun", {31'd0, overrun}, 32'd0);
    check("rst addr_err", {31'd0, addr_err}, 32'd0);
    check("rst data_out", {24'd0, LCD_data_out}, 32'h00);
    check("rst oe", {31'd0, LCD_data_oe}, 32'd0);
    check("rst rd_char", {24'd0, rd_char}, 32'h20);
    check("rst state", {30'd0, dbg_state_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_buf();

    // ---------------- table: two-line message ----------------
    vecs[0] = '{1'b0, 8'h84, 7'h04, 8'd0};
    for (int i = 0; i < 6; i++) begin
      vecs[1 + i] = '{1'b1, s1[i], 7'(7'h05 + i), 8'(i + 1)};
      model[4 + i] = s1[i];
    end
    vecs[7] = '{1'b0, 8'hC0, 7'h40, 8'd6};
    for (int i = 0; i < 16; i++) begin
      vecs[8 + i] = '{1'b1, s2[i], (i == 15) ? 7'h00 : 7'(7'h41 + i), 8'(7 + i)};
      model[16 + i] = s2[i];
    end
    for (int i = 0; i < 24; i++) begin
      bus_write(vecs[i].rs, vecs[i].data);
      check($sformatf("vec%0d cursor", i), {25'd0, cursor}, {25'd0, vecs[i].exp_cursor});
      check($sformatf("vec%0d wr_count", i), {24'd0, wr_count}, {24'd0, vecs[i].exp_wr});
    end
    check("msg overrun", {31'd0, overrun}, 32'd0);
    check_all_buf();

    // ---------------- write during busy ----------------
    do_reset();
    bus_strobe(1'b0, 1'b1, "A");
    bus_strobe(1'b0, 1'b1, "B");
    repeat (CMD_CYCLES + 2) @(negedge clk);
    model[0] = "A";
    check("ovr overrun", {31'd0, overrun}, 32'd1);
    check("ovr wr_count", {24'd0, wr_count}, 32'd1);
    check("ovr cursor", {25'd0, cursor}, 32'h01);
    check_buf(0);
    check_buf(1);

    // ---------------- fill, clear, poll status ----------------
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bus_write(1'b1, 8'(8'h61 + (i % 26)));
      model[i] = 8'(8'h61 + (i % 26));
    end
    check("fill cursor", {25'd0, cursor}, 32'h00);
    check("fill wr_count", {24'd0, wr_count}, 32'd32);
    check_buf(31);
    bus_strobe(1'b0, 1'b0, 8'h01);
    LCD_rw = 1'b1; LCD_rs = 1'b0; LCD_en = 1'b1;
    n = 0;
    for (int i = 0; i < CLEAR_CYCLES + 20; i++) begin
      @(negedge clk);
      if (LCD_data_out[7]) n++;
    end
    check("clear busy cycles", n, CLEAR_CYCLES);
    check("clear status", {24'd0, LCD_data_out}, 32'h00);
    check("clear oe", {31'd0, LCD_data_oe}, 32'd1);
    LCD_en = 1'b0;
    @(negedge clk);
    check("oe drop", {31'd0, LCD_data_oe}, 32'd0);
    LCD_rw = 1'b0;
    repeat (2) @(negedge clk);
    check("status no overrun", {31'd0, overrun}, 32'd0);
    check("status not busy", {31'd0, busy}, 32'd0);
    model_clear();
    check_all_buf();

    // ---------------- line wrap, bad address, nop command ----------------
    do_reset();
    bus_write(1'b0, 8'h8F);
    bus_write(1'b1, "X");
    bus_write(1'b1, "Y");
    model[15] = "X"; model[16] = "Y";
    check("wrap cursor", {25'd0, cursor}, 32'h41);
    check_buf(15);
    check_buf(16);
    bus_write(1'b0, 8'hA0);
    check("bad addr err", {31'd0, addr_err}, 32'd1);
    check("bad addr cursor", {25'd0, cursor}, 32'h41);
    bus_strobe(1'b0, 1'b0, 8'h38);
    count_busy(12, n);
    check("nop busy cycles", n, CMD_CYCLES);
    check("nop cursor", {25'd0, cursor}, 32'h41);
    check_all_buf();

    // ---------------- data read ----------------
    bus_write(1'b0, 8'h8F);
    @(negedge clk);
    LCD_rw = 1'b1; LCD_rs = 1'b1; LCD_en = 1'b1;
    repeat (2) @(negedge clk);
    check("dread oe", {31'd0, LCD_data_oe}, 32'd1);
    check("dread data", {24'd0, LCD_data_out}, {24'd0, 8'h58});
    LCD_en = 1'b0;
    @(negedge clk);
    LCD_rw = 1'b0;
    check("dread busy", {31'd0, busy}, 32'd1);
    repeat (CMD_CYCLES + 2) @(negedge clk);
    check("dread cursor", {25'd0, cursor}, 32'h40);
    check("dread overrun", {31'd0, overrun}, 32'd0);
    check("dread wr_count", {24'd0, wr_count}, 32'd2);

    // ---------------- reset during clear ----------------
    do_reset();
    bus_write(1'b0, 8'hC4);
    bus_write(1'b1, "Z");
    model[20] = "Z";
    check_buf(20);
    bus_strobe(1'b0, 1'b0, 8'h01);
    repeat (9) @(negedge clk);
    check("mid clear busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst cursor", {25'd0, cursor}, 32'h00);
    check("async rst wr_count", {24'd0, wr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (CLEAR_CYCLES + 5) @(negedge clk);
    check("post rst busy", {31'd0, busy}, 32'd0);
    check("post rst state", {30'd0, dbg_state_o}, 32'd0);
    check_all_buf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
